// File: rtl/sync_timing_gen.sv
// Line/frame timing generator: emits sync, f_sync, endLine and endFrame strobes plus
// the active-pixel qualifier and x/y/frame position counters for the Control block.
module sync_timing_gen #(
  parameter int ACT_PIX   = 16,
  parameter int HBLANK    = 4,
  parameter int ACT_LINES = 8,
  parameter int VBLANK    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        f_sync,
  output logic        sync,
  output logic        endLine,
  output logic        endFrame,
  output logic        active,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  // state   | meaning
  // IDLE    | stopped, waiting for enable
  // SYNC    | one-cycle line start
  // ACTIVE  | ACT_PIX active pixel cycles
  // HBLANK  | HBLANK blank cycles after each active line
  // VBLANK  | VBLANK blank line periods after the last active line
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_VBLANK = 3'd4;

  localparam logic [11:0] LP_X_LAST     = 12'(ACT_PIX - 1);
  localparam logic [12:0] LP_Y_LAST_ACT = 13'(ACT_LINES - 1);
  localparam logic [12:0] LP_Y_LAST_V   = 13'(ACT_LINES + VBLANK - 1);
  localparam logic [12:0] LP_HB_LAST    = 13'(HBLANK - 1);
  localparam logic [12:0] LP_LINE_LAST  = 13'(ACT_PIX + HBLANK);

  logic [2:0]  r_state;
  logic [11:0] r_x;
  logic [12:0] r_y;
  logic [12:0] r_cnt;
  logic        r_f_sync, r_sync, r_end_line, r_end_frame, r_active, r_busy;
  logic [11:0] r_x_pos, r_y_pos;
  logic [7:0]  r_frame_cnt;

  logic [2:0]  w_state_n;
  logic [11:0] w_x_n;
  logic [12:0] w_y_n;
  logic [12:0] w_cnt_n;
  logic        w_line_end, w_frame_end;
  logic        w_end_line_n;

  always_comb begin
    w_state_n   = r_state;
    w_x_n       = r_x;
    w_y_n       = r_y;
    w_cnt_n     = r_cnt;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE:   if (enable) w_state_n = S_SYNC;
      S_SYNC: begin
        w_state_n = S_ACTIVE;
        w_x_n     = '0;
      end
      S_ACTIVE: begin
        if (r_x == LP_X_LAST) begin
          w_x_n = '0;
          if (HBLANK > 0) begin
            w_state_n = S_HBLANK;
            w_cnt_n   = LP_HB_LAST;
          end else begin
            w_line_end = 1'b1;
          end
        end else begin
          w_x_n = r_x + 12'd1;
        end
      end
      S_HBLANK: begin
        if (r_cnt == '0) w_line_end = 1'b1;
        else             w_cnt_n = r_cnt - 13'd1;
      end
      S_VBLANK: begin
        if (r_cnt == '0) begin
          if (r_y == LP_Y_LAST_V) begin
            w_frame_end = 1'b1;
          end else begin
            w_y_n   = r_y + 13'd1;
            w_cnt_n = LP_LINE_LAST;
          end
        end else begin
          w_cnt_n = r_cnt - 13'd1;
        end
      end
      default:  w_state_n = S_IDLE;
    endcase

    if (w_line_end) begin
      if (r_y < LP_Y_LAST_ACT) begin
        w_y_n     = r_y + 13'd1;
        w_state_n = S_SYNC;
      end else if (VBLANK > 0) begin
        w_y_n     = r_y + 13'd1;
        w_state_n = S_VBLANK;
        w_cnt_n   = LP_LINE_LAST;
      end else begin
        w_frame_end = 1'b1;
      end
    end

    // enable only matters here: a running frame always completes
    if (w_frame_end) begin
      w_y_n     = '0;
      w_state_n = enable ? S_SYNC : S_IDLE;
    end
  end

  assign w_end_line_n = (w_state_n == S_ACTIVE) && (w_x_n == LP_X_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_f_sync    <= 1'b0;
      r_sync      <= 1'b0;
      r_end_line  <= 1'b0;
      r_end_frame <= 1'b0;
      r_active    <= 1'b0;
      r_busy      <= 1'b0;
      r_x_pos     <= '0;
      r_y_pos     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_cnt       <= w_cnt_n;
      r_sync      <= (w_state_n == S_SYNC);
      r_f_sync    <= (w_state_n == S_SYNC) && (w_y_n == '0);
      r_active    <= (w_state_n == S_ACTIVE);
      r_end_line  <= w_end_line_n;
      r_end_frame <= w_end_line_n && (w_y_n == LP_Y_LAST_ACT);
      r_busy      <= (w_state_n != S_IDLE);
      r_x_pos     <= (w_state_n == S_ACTIVE) ? w_x_n : 12'd0;
      r_y_pos     <= w_y_n[11:0];
      if (r_end_frame) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign f_sync    = r_f_sync;
  assign sync      = r_sync;
  assign endLine   = r_end_line;
  assign endFrame  = r_end_frame;
  assign active    = r_active;
  assign x_pos     = r_x_pos;
  assign y_pos     = r_y_pos;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sync_timing_gen.sv
// Bench for sync_timing_gen: three geometries checked cycle by cycle against a
// frame-position model (line = p / period, column = p % period).
module tb_sync_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en [3];

  logic        f_sync [3], sync [3], end_line [3], end_frame [3], active [3], busy [3];
  logic [11:0] x_pos [3], y_pos [3];
  logic [7:0]  frame_cnt [3];

  int G_AP [3] = '{16, 4, 1};
  int G_HB [3] = '{4, 0, 0};
  int G_AL [3] = '{8, 2, 1};
  int G_VB [3] = '{2, 0, 0};

  bit        m_run [3];
  int        m_p [3];
  logic [7:0] m_fc [3];

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  always #5 clk = ~clk;

  sync_timing_gen #(.ACT_PIX(16), .HBLANK(4), .ACT_LINES(8), .VBLANK(2)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .f_sync(f_sync[0]), .sync(sync[0]),
    .endLine(end_line[0]), .endFrame(end_frame[0]), .active(active[0]),
    .x_pos(x_pos[0]), .y_pos(y_pos[0]), .frame_cnt(frame_cnt[0]), .busy(busy[0]));

  sync_timing_gen #(.ACT_PIX(4), .HBLANK(0), .ACT_LINES(2), .VBLANK(0)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .f_sync(f_sync[1]), .sync(sync[1]),
    .endLine(end_line[1]), .endFrame(end_frame[1]), .active(active[1]),
    .x_pos(x_pos[1]), .y_pos(y_pos[1]), .frame_cnt(frame_cnt[1]), .busy(busy[1]));

  sync_timing_gen #(.ACT_PIX(1), .HBLANK(0), .ACT_LINES(1), .VBLANK(0)) u_dut2 (
    .clk(clk), .rst(rst), .enable(en[2]), .f_sync(f_sync[2]), .sync(sync[2]),
    .endLine(end_line[2]), .endFrame(end_frame[2]), .active(active[2]),
    .x_pos(x_pos[2]), .y_pos(y_pos[2]), .frame_cnt(frame_cnt[2]), .busy(busy[2]));

  // {busy, f_sync, sync, endLine, endFrame, active, x_pos, y_pos, frame_cnt}
  function automatic logic [37:0] model_out(int g);
    int lp, line, col;
    logic fs, sy, el, ef, ac;
    logic [11:0] x, y;
    fs = 0; sy = 0; el = 0; ef = 0; ac = 0; x = '0; y = '0;
    if (m_run[g]) begin
      lp   = 1 + G_AP[g] + G_HB[g];
      line = m_p[g] / lp;
      col  = m_p[g] % lp;
      y    = 12'(line);
      if (line < G_AL[g]) begin
        sy = (col == 0);
        ac = (col >= 1) && (col <= G_AP[g]);
        x  = ac ? 12'(col - 1) : 12'd0;
        el = (col == G_AP[g]);
        fs = sy && (line == 0);
        ef = el && (line == G_AL[g] - 1);
      end
    end
    return {m_run[g], fs, sy, el, ef, ac, x, y, m_fc[g]};
  endfunction

  function automatic logic [37:0] dut_out(int g);
    return {busy[g], f_sync[g], sync[g], end_line[g], end_frame[g], active[g],
            x_pos[g], y_pos[g], frame_cnt[g]};
  endfunction

  task automatic model_step(int g, logic e);
    logic [37:0] o;
    int fl;
    o  = model_out(g);
    fl = (G_AL[g] + G_VB[g]) * (1 + G_AP[g] + G_HB[g]);
    if (o[33]) m_fc[g] = m_fc[g] + 8'd1;
    if (!m_run[g]) begin
      if (e) begin m_run[g] = 1; m_p[g] = 0; end
    end else if (m_p[g] == fl - 1) begin
      if (e) m_p[g] = 0;
      else begin m_run[g] = 0; m_p[g] = 0; end
    end else begin
      m_p[g] = m_p[g] + 1;
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin m_run[g] = 0; m_p[g] = 0; m_fc[g] = '0; end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int g = 0; g < 3; g++) model_step(g, en[g]);
    t++;
    #1;
  endtask

  task automatic stop_dut(int g);
    int k;
    en[g] = 1'b0;
    k = 0;
    while (busy[g] && k < 600) begin tick(); k++; end
    n_checks++;
    if (busy[g]) begin
      n_fail++;
      $display("FAIL stop_timeout g%0d: busy=%0b required 0", g, busy[g]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int g = 0; g < 3; g++) en[g] = 1'b0;
    model_reset();
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (dut_out(g) !== 38'd0) begin
        n_fail++;
        $display("FAIL reset_state g%0d: got %h required 0", g, dut_out(g));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int t_fs, gap, n_el, el_at_ef;
    logic prev_ef;
    logic [7:0] fc_prev;
    t_fs = -1; gap = -1; n_el = 0; el_at_ef = -1; prev_ef = 0; fc_prev = 0;
    en[0] = 1'b1;
    tick();
    n_checks++;
    if ({sync[0], f_sync[0], y_pos[0]} !== {1'b1, 1'b1, 12'd0}) begin
      n_fail++;
      $display("FAIL first_sync: got sync=%0b f_sync=%0b y=%0d required 1 1 0",
               sync[0], f_sync[0], y_pos[0]);
    end
    t_fs = t;
    for (int i = 0; i < 430; i++) begin
      tick();
      n_checks++;
      if (dut_out(0) !== model_out(0)) begin
        n_fail++;
        $display("FAIL cont_cycle t=%0d: got %h required %h", t, dut_out(0), model_out(0));
      end
      if (prev_ef) begin
        n_checks++;
        if (frame_cnt[0] !== fc_prev + 8'd1) begin
          n_fail++;
          $display("FAIL cont_frame_cnt: got %0d required %0d", frame_cnt[0], fc_prev + 8'd1);
        end
      end
      if (end_line[0]) n_el++;
      if (end_frame[0] && el_at_ef < 0) el_at_ef = n_el;
      if (f_sync[0] && gap < 0) gap = t - t_fs;
      prev_ef = end_frame[0];
      fc_prev = frame_cnt[0];
    end
    n_checks++;
    if (gap !== 210) begin
      n_fail++;
      $display("FAIL fsync_period: got %0d required 210", gap);
    end
    n_checks++;
    if (el_at_ef !== 8) begin
      n_fail++;
      $display("FAIL endframe_line: got %0d required 8", el_at_ef);
    end
    stop_dut(0);
  endtask

  task automatic test_drop_enable();
    int n_sync, t_fs, t_fall, k, bad;
    logic [7:0] fc0;
    n_sync = 0; t_fs = -1; t_fall = -1; k = 0; bad = 0;
    fc0 = frame_cnt[0];
    en[0] = 1'b1;
    while (t_fall < 0 && k < 400) begin
      tick(); k++;
      n_checks++;
      if (dut_out(0) !== model_out(0)) begin
        n_fail++;
        $display("FAIL drop_cycle t=%0d: got %h required %h", t, dut_out(0), model_out(0));
      end
      if (f_sync[0] && t_fs < 0) t_fs = t;
      if (sync[0]) begin
        n_sync++;
        if (n_sync == 3) en[0] = 1'b0;
      end
      if (!busy[0] && t_fs >= 0) t_fall = t;
    end
    n_checks++;
    if (t_fall - t_fs !== 210) begin
      n_fail++;
      $display("FAIL drop_busy_fall: got %0d required 210", t_fall - t_fs);
    end
    n_checks++;
    if (n_sync !== 8) begin
      n_fail++;
      $display("FAIL drop_sync_count: got %0d required 8", n_sync);
    end
    n_checks++;
    if (frame_cnt[0] !== fc0 + 8'd1) begin
      n_fail++;
      $display("FAIL drop_frame_cnt: got %0d required %0d", frame_cnt[0], fc0 + 8'd1);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sync[0] || busy[0]) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drop_idle_quiet: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    en[0] = 1'b1;
    while (!(active[0] && y_pos[0] == 12'd4 && x_pos[0] == 12'd7) && k < 500) begin
      tick(); k++;
      n_checks++;
      if (dut_out(0) !== model_out(0)) begin
        n_fail++;
        $display("FAIL arst_cycle t=%0d: got %h required %h", t, dut_out(0), model_out(0));
      end
    end
    n_checks++;
    if (!(active[0] && y_pos[0] == 12'd4 && x_pos[0] == 12'd7)) begin
      n_fail++;
      $display("FAIL arst_reach: got y=%0d x=%0d required y=4 x=7", y_pos[0], x_pos[0]);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (dut_out(g) !== 38'd0) begin
        n_fail++;
        $display("FAIL arst_immediate g%0d: got %h required 0", g, dut_out(g));
      end
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({sync[0], f_sync[0], y_pos[0]} !== {1'b1, 1'b1, 12'd0}) begin
      n_fail++;
      $display("FAIL arst_restart: got sync=%0b f_sync=%0b y=%0d required 1 1 0",
               sync[0], f_sync[0], y_pos[0]);
    end
    stop_dut(0);
  endtask

  task automatic test_small_geom();
    int last_sync;
    logic prev_el, prev_ef;
    last_sync = -1; prev_el = 0; prev_ef = 0;
    en[1] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if (dut_out(1) !== model_out(1)) begin
        n_fail++;
        $display("FAIL small_cycle t=%0d: got %h required %h", t, dut_out(1), model_out(1));
      end
      if (sync[1]) begin
        if (last_sync >= 0) begin
          n_checks++;
          if (t - last_sync !== 5) begin
            n_fail++;
            $display("FAIL small_sync_period: got %0d required 5", t - last_sync);
          end
        end
        last_sync = t;
      end
      if (prev_el) begin
        n_checks++;
        if (sync[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL small_el_to_sync: got sync=%0b required 1", sync[1]);
        end
      end
      if (prev_ef) begin
        n_checks++;
        if ({sync[1], f_sync[1]} !== 2'b11) begin
          n_fail++;
          $display("FAIL small_ef_to_fsync: got %b required 11", {sync[1], f_sync[1]});
        end
      end
      prev_el = end_line[1];
      prev_ef = end_frame[1];
    end
    stop_dut(1);
  endtask

  task automatic test_tiny_geom();
    bit wrapped;
    logic [7:0] fc_prev;
    wrapped = 0;
    fc_prev = frame_cnt[2];
    en[2] = 1'b1;
    for (int i = 0; i < 520; i++) begin
      tick();
      n_checks++;
      if (dut_out(2) !== model_out(2)) begin
        n_fail++;
        $display("FAIL tiny_cycle t=%0d: got %h required %h", t, dut_out(2), model_out(2));
      end
      if (fc_prev == 8'd255 && frame_cnt[2] == 8'd0) wrapped = 1;
      fc_prev = frame_cnt[2];
    end
    n_checks++;
    if (wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL tiny_fc_wrap: got wrapped=%0b required 1", wrapped);
    end
    stop_dut(2);
  endtask

  task automatic test_random_enable();
    int n_fs, idle_sync;
    n_fs = 0; idle_sync = 0;
    en[0] = 1'b1;
    tick();
    if (f_sync[0]) n_fs++;
    for (int i = 0; i < 300; i++) begin
      en[0] = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n_checks++;
      if (dut_out(0) !== model_out(0)) begin
        n_fail++;
        $display("FAIL rand_cycle t=%0d: got %h required %h", t, dut_out(0), model_out(0));
      end
      if (f_sync[0]) n_fs++;
      if (sync[0] && !busy[0]) idle_sync++;
    end
    n_checks++;
    if (n_fs !== 1) begin
      n_fail++;
      $display("FAIL rand_frame_count: got %0d frames required 1", n_fs);
    end
    n_checks++;
    if (idle_sync !== 0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_idle: got idle_sync=%0d busy=%0b required 0 0", idle_sync, busy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_drop_enable();
    test_async_reset();
    test_small_geom();
    test_tiny_geom();
    test_random_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
